sparc_mem_unit: RTL
===================

Name: sparc_mem_unit

Overview:
- Parametrised byte-addressable memory unit serving the SPARC datapath over the mov/MOC handshake.
- Supports byte, halfword and word transfers, big-endian, with optional sign extension on loads.
- Replaces the fixed-latency memory stub with configurable width, depth and wait states, and adds misalignment detection.
- Sits beside the DataPath and is driven by the ControlUnit's mov, r_w and type outputs.

Parameters:
- DATA_W, 32, load/store data width in bits; must be 32.
- ADDR_W, 9, byte-address width; memory depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 2, extra access cycles inserted before completion; range 0..15.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clr  in  1  synchronous active-low reset.
- mov  in  1  memory operation valid; held high by the control unit until MOC.
- r_w  in  1  1 = read (load), 0 = write (store).
- type  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data; byte in [7:0], halfword in [15:0].
- rdata  out  DATA_W  load result, registered.
- MOC  out  1  memory operation complete.
- misalign  out  1  completed access was misaligned.

Behaviour:
- Reset (Clr=0 at a rising edge):
  - state←IDLE, counter←0, MOC←0, rdata←0, misalign←0.
  - Memory array contents are not cleared.
  - Reset mid-operation aborts the request; an uncommitted write is dropped.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - MOC=0.
  - If mov=1: latch r_w, type, sign, addr, wdata; counter←WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - If counter≠0: decrement.
  - If counter=0, the commit edge does the following, then goes to DONE:
    - Write: byte lanes written.
    - Read: rdata updated.
    - misalign flag computed.
    - MOC←1.
- DONE:
  - MOC stays 1 while mov=1.
  - When mov=0: MOC←0 and go to IDLE.
  - A new request needs mov low for at least one cycle.
- Latency: with mov first high in cycle 0, MOC is first high in cycle WAIT_CYCLES+2.
- Changes to mov or the request inputs after latch and before DONE are ignored; the request is committed.
- Byte order is big-endian. Word at address A: mem[A]=wdata[31:24] … mem[A+3]=wdata[7:0].
- Halfword at A: mem[A]=wdata[15:8], mem[A+1]=wdata[7:0].
- Loads:
  - Byte/halfword are placed in the low bits of rdata.
  - Upper bits are filled from bit 7 (byte) or bit 15 (halfword) when sign=1, otherwise with 0.
- rdata is unchanged by writes and holds its value until the next read commits.
- Misalignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - Byte accesses are never misaligned.
- Address arithmetic is modulo 2**ADDR_W. Aligned accesses never wrap.

Optional Feature:
- Macro SPARC_MEM_ALIGN_TRAP_EN.
- Defined:
  - Misaligned access performs no write and leaves rdata unchanged.
  - MOC is asserted normally with misalign=1.
  - misalign clears on the next commit or on reset.
- Undefined:
  - The low address bits are forced to the aligned value (addr[0] for halfword, addr[1:0] for word).
  - The access proceeds normally, and misalign is tied to 0.

Decomposition:
- Shared definitions file (sparc_mem_defs.vh), holding:
  - Access-type encodings: TYPE_BYTE, TYPE_HALF, TYPE_WORD.
  - State encodings: IDLE, ACCESS, DONE.
  - WAIT_CYCLES limit.
- One sub-module, sparc_mem_lane: combinational byte-lane select for stores, and extraction plus sign/zero extension for loads.
- The FSM and memory array stay in sparc_mem_unit.

Test Plan:
1. Word store then load, WAIT_CYCLES=2:
   - Write 0xDEADBEEF at addr 0x010, then read it.
   - rdata=0xDEADBEEF; MOC first high in cycle 4 after mov.
   - mem[0x010]=0xDE, mem[0x013]=0xEF.
2. Byte load with extension after step 1:
   - Read byte at 0x013 with sign=1 → rdata=0xFFFFFFEF.
   - Same read with sign=0 → rdata=0x000000EF.
   - Halfword at 0x010 with sign=1 → rdata=0xFFFFDEAD.
3. Handshake hold:
   - Keep mov high for 5 cycles after MOC → MOC stays 1 and no second access occurs.
   - Drop mov → MOC=0 on the next edge, state IDLE.
4. Misaligned word store of 0x11223344 at 0x012:
   - With SPARC_MEM_ALIGN_TRAP_EN: mem unchanged, misalign=1.
   - Without it: write goes to 0x010, misalign=0.
5. Reset mid-operation:
   - Issue a store of 0xCAFEBABE to 0x020 and assert Clr=0 in ACCESS with counter≠0.
   - Result: MOC=0, rdata=0, mem[0x020..0x023] unchanged.
6. WAIT_CYCLES=0:
   - Read → MOC first high in cycle 2.
   - Back-to-back requests separated by one low-mov cycle both complete correctly.

Source files
------------

// File: rtl/sparc_mem_unit_pkg.sv
// Shared definitions for the SPARC memory unit: access-type encodings,
// FSM state encoding, wait-state limit and the alignment rule.
package sparc_mem_unit_pkg;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] ty, input logic [1:0] a);
    case (ty)
      TYPE_BYTE: return 1'b0;
      TYPE_HALF: return a[0];
      default:   return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/sparc_mem_lane.sv
// Byte-lane steering: big-endian store lane select and load extraction with
// sign/zero extension. Lane 0 is the byte at the effective address.
module sparc_mem_lane
  import sparc_mem_unit_pkg::*;
(
  input  logic [1:0]      i_type,
  input  logic            i_sign,
  input  logic [31:0]     i_wdata,
  input  logic [3:0][7:0] i_rbytes,
  output logic [3:0]      o_we,
  output logic [3:0][7:0] o_wbytes,
  output logic [31:0]     o_rdata
);

  always_comb begin
    o_we     = 4'b0000;
    o_wbytes = '0;
    o_rdata  = '0;
    case (i_type)
      TYPE_BYTE: begin
        o_we        = 4'b0001;
        o_wbytes[0] = i_wdata[7:0];
        o_rdata     = {{24{i_sign & i_rbytes[0][7]}}, i_rbytes[0]};
      end
      TYPE_HALF: begin
        o_we        = 4'b0011;
        o_wbytes[0] = i_wdata[15:8];
        o_wbytes[1] = i_wdata[7:0];
        o_rdata     = {{16{i_sign & i_rbytes[0][7]}}, i_rbytes[0], i_rbytes[1]};
      end
      default: begin
        o_we        = 4'b1111;
        o_wbytes[0] = i_wdata[31:24];
        o_wbytes[1] = i_wdata[23:16];
        o_wbytes[2] = i_wdata[15:8];
        o_wbytes[3] = i_wdata[7:0];
        o_rdata     = {i_rbytes[0], i_rbytes[1], i_rbytes[2], i_rbytes[3]};
      end
    endcase
  end

endmodule

// File: rtl/sparc_mem_unit.sv
// Byte-addressable memory unit on the mov/MOC handshake with configurable wait
// states. Define SPARC_MEM_ALIGN_TRAP_EN to suppress misaligned accesses instead of aligning them.
module sparc_mem_unit
  import sparc_mem_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              mov,
  input  logic              r_w,
  input  logic [1:0]        mtype,   // access type; "type" is a reserved word
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MOC,
  output logic              misalign,
  output logic [1:0]        dbg_state
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: the control unit holds mov until MOC; MOC stays high until mov
  // drops, and a new request is accepted only after mov was low for a cycle.
  state_e              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_rw, r_sign;
  logic [1:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_moc, r_misalign;
  logic [7:0]          r_mem [DEPTH];

  logic                w_latch, w_commit;
  logic [ADDR_W-1:0]   w_ea;
  logic                w_ok, w_flag;
  logic [3:0][7:0]     w_rbytes;
  logic [3:0]          w_we;
  logic [3:0][7:0]     w_wbytes;
  logic [31:0]         w_ld;

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE:    if (mov) begin w_latch = 1'b1; w_next = ACCESS; end
      ACCESS:  if (r_cnt == 4'd0) begin w_commit = 1'b1; w_next = DONE; end
      DONE:    if (!mov) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef SPARC_MEM_ALIGN_TRAP_EN
  logic w_mis;
  always_comb begin
    w_mis  = is_misaligned(r_type, r_addr[1:0]);
    w_ea   = r_addr;
    w_ok   = !w_mis;
    w_flag = w_mis;
  end
`else
  // Misaligned requests are silently pulled down to the natural boundary.
  always_comb begin
    case (r_type)
      TYPE_BYTE: w_ea = r_addr;
      TYPE_HALF: w_ea = {r_addr[ADDR_W-1:1], 1'b0};
      default:   w_ea = {r_addr[ADDR_W-1:2], 2'b00};
    endcase
    w_ok   = 1'b1;
    w_flag = 1'b0;
  end
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_rbytes[i] = r_mem[w_ea + ADDR_W'(i)];
    end
  end

  sparc_mem_lane u_lane (
    .i_type   (r_type),
    .i_sign   (r_sign),
    .i_wdata  (r_wdata),
    .i_rbytes (w_rbytes),
    .o_we     (w_we),
    .o_wbytes (w_wbytes),
    .o_rdata  (w_ld)
  );

  // Array has no reset; Clr only gates the commit so an aborted store is dropped.
  always_ff @(posedge Clk) begin
    if (Clr && w_commit && !r_rw && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) r_mem[w_ea + ADDR_W'(i)] <= w_wbytes[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_moc      <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_rw       <= 1'b1;
      r_type     <= TYPE_BYTE;
      r_sign     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_rw    <= r_w;
        r_type  <= mtype;
        r_sign  <= sign;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_moc      <= 1'b1;
        r_misalign <= w_flag;
        if (r_rw && w_ok) r_rdata <= w_ld;
      end else if (r_state == DONE && !mov) begin
        r_moc <= 1'b0;
      end
    end
  end

  assign rdata     = r_rdata;
  assign MOC       = r_moc;
  assign misalign  = r_misalign;
  assign dbg_state = r_state;

endmodule
